// File: rtl/tx_packet_ctrl.sv
// tx_packet_ctrl: sequences the serial transmit path. Pulls bytes from a
// first-word-fall-through TX FIFO, hands each to the shift register and keeps the
// transmit timer running until a short (SHORT_LEN) or long (LONG_LEN) packet is out.
// Every packet end, abort or underrun is followed by IDLE_GAP idle cycles.
// Optional feature: define TX_PKT_LEN_CHECK_EN to cross-check the timer's data_sent
// against the internal byte count and raise the sticky len_err flag on disagreement.
module tx_packet_ctrl #(
  parameter int SHORT_LEN = 5,
  parameter int LONG_LEN  = 34,
  parameter int IDLE_GAP  = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_req,
  input  logic       tx_short,
  input  logic       abort,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rdata,
  output logic       fifo_read,
  output logic       load_byte,
  output logic [7:0] tx_byte,
  output logic       transmitting,
  output logic       transmit_empty,
  input  logic       byte_sent,
  input  logic       data_sent,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun,
  output logic       len_err
);

  localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_GAP - 1);
  localparam logic [5:0] SHORT_L = 6'(SHORT_LEN);
  localparam logic [5:0] LONG_L  = 6'(LONG_LEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4,
    S_GAP   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic             pending_q, pending_d;
  logic             pend_type_q, pend_type_d;
  logic             type_q, type_d;
  logic [5:0]       byte_cnt_q, byte_cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             underrun_q, underrun_d;

  // Helpers derived from the current packet position.
  logic [5:0] pkt_len;
  logic [5:0] cnt_inc;
  logic       last_byte;
  logic       byte_accept;

  assign pkt_len   = type_q ? SHORT_L : LONG_L;
  assign cnt_inc   = byte_cnt_q + 6'd1;
  assign last_byte = (cnt_inc == pkt_len);

  // Moore-style status outputs straight from registered state.
  assign tx_busy        = (state_q != S_IDLE);
  assign transmit_empty = (state_q != S_IDLE) & type_q;
  assign tx_byte        = byte_q;
  assign tx_underrun    = underrun_q;

  // Next-state logic, per-state strobes, request pending and abort override.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    pend_type_d  = pend_type_q;
    type_d       = type_q;
    byte_cnt_d   = byte_cnt_q;
    byte_d       = byte_q;
    gap_cnt_d    = gap_cnt_q;
    underrun_d   = 1'b0;
    fifo_read    = 1'b0;
    load_byte    = 1'b0;
    transmitting = 1'b0;
    tx_done      = 1'b0;
    byte_accept  = 1'b0;

    // One-deep request holder; a request arriving while one is held is dropped.
    if (tx_req && !pending_q) begin
      pending_d   = 1'b1;
      pend_type_d = tx_short;
    end

    case (state_q)
      S_IDLE: begin
        // Start only once the FIFO has data; otherwise keep the request held.
        if (pending_q && !fifo_empty) begin
          type_d     = pend_type_q;
          byte_cnt_d = 6'd0;
          pending_d  = 1'b0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!fifo_empty) begin
          fifo_read = 1'b1;
          byte_d    = fifo_rdata;
          state_d   = S_LOAD;
        end else begin
          underrun_d = 1'b1;
          gap_cnt_d  = '0;
          state_d    = S_GAP;
        end
      end
      S_LOAD: begin
        load_byte = 1'b1;
        state_d   = S_SEND;
      end
      S_SEND: begin
        transmitting = 1'b1;
        if (byte_sent) begin
          byte_accept = 1'b1;
          if (last_byte) begin
            // Clear instead of storing LEN so the count stays below LONG_LEN.
            byte_cnt_d = 6'd0;
            state_d    = S_DONE;
          end else begin
            byte_cnt_d = cnt_inc;
            state_d    = S_FETCH;
          end
        end
      end
      S_DONE: begin
        tx_done   = 1'b1;
        gap_cnt_d = '0;
        state_d   = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over byte completion, underrun and done; already-idle states ignore it.
    if (abort && (state_q != S_IDLE) && (state_q != S_GAP)) begin
      state_d     = S_GAP;
      gap_cnt_d   = '0;
      byte_cnt_d  = byte_cnt_q;
      byte_d      = byte_q;
      underrun_d  = 1'b0;
      fifo_read   = 1'b0;
      load_byte   = 1'b0;
      tx_done     = 1'b0;
      byte_accept = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      pending_q   <= 1'b0;
      pend_type_q <= 1'b0;
      type_q      <= 1'b0;
      byte_cnt_q  <= 6'd0;
      byte_q      <= 8'h00;
      gap_cnt_q   <= '0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      pend_type_q <= pend_type_d;
      type_q      <= type_d;
      byte_cnt_q  <= byte_cnt_d;
      byte_q      <= byte_d;
      gap_cnt_q   <= gap_cnt_d;
      underrun_q  <= underrun_d;
    end
  end

`ifdef TX_PKT_LEN_CHECK_EN
  logic len_err_q, len_err_d;

  // Timer's end-of-packet indication must agree with our own count on every accepted byte.
  always_comb begin
    len_err_d = len_err_q | (byte_accept & (data_sent ^ last_byte));
  end

  // Sticky length-mismatch flag, cleared only by reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= len_err_d;
    end
  end

  assign len_err = len_err_q;
`else
  logic unused_len_check;

  assign len_err          = 1'b0;
  assign unused_len_check = data_sent ^ byte_accept;
`endif

endmodule

// File: tb/tb_tx_packet_ctrl.sv
`timescale 1ns/1ps
module tb_tx_packet_ctrl;

  localparam int SHORT_LEN = 5;
  localparam int LONG_LEN  = 34;
  localparam int IDLE_GAP  = 2;
  localparam int BIT_CYC   = 3;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_req = 1'b0;
  logic       tx_short = 1'b0;
  logic       abort = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rdata = 8'h00;
  logic       byte_sent = 1'b0;
  logic       data_sent = 1'b0;
  logic       fifo_read, load_byte, transmitting, transmit_empty;
  logic       tx_busy, tx_done, tx_underrun, len_err;
  logic [7:0] tx_byte;

  int errors = 0;
  int checks = 0;

  // FIFO storage: main writes entries and wr_ptr, the FIFO process owns rd_ptr.
  logic [7:0] fifo_mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;

  // Requests issued by main, consumed by the compare process at packet start.
  logic req_type [0:63];
  int req_wr = 0;
  int req_rd = 0;

  // Observed packet activity, written only by the compare process.
  logic [7:0] log_mem [0:255];
  int log_n = 0;
  int done_cnt = 0;
  int underrun_cnt = 0;

  // Timer model state.
  int tm_idx = 0;
  int tm_cnt = 0;
  int ds_force = 0;

  always #5 clk = ~clk;

  tx_packet_ctrl #(
    .SHORT_LEN (SHORT_LEN),
    .LONG_LEN  (LONG_LEN),
    .IDLE_GAP  (IDLE_GAP)
  ) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .tx_req         (tx_req),
    .tx_short       (tx_short),
    .abort          (abort),
    .fifo_empty     (fifo_empty),
    .fifo_rdata     (fifo_rdata),
    .fifo_read      (fifo_read),
    .load_byte      (load_byte),
    .tx_byte        (tx_byte),
    .transmitting   (transmitting),
    .transmit_empty (transmit_empty),
    .byte_sent      (byte_sent),
    .data_sent      (data_sent),
    .tx_busy        (tx_busy),
    .tx_done        (tx_done),
    .tx_underrun    (tx_underrun),
    .len_err        (len_err)
  );

  function automatic int plen(input logic t);
    return t ? SHORT_LEN : LONG_LEN;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First-word-fall-through FIFO: pop observed mid-cycle, applied after the edge.
  initial begin : fifo_model
    logic do_pop;
    forever begin
      @(negedge clk);
      do_pop = fifo_read && n_rst;
      @(posedge clk);
      #1;
      if (do_pop && rd_ptr < wr_ptr) rd_ptr++;
      fifo_empty = (rd_ptr == wr_ptr);
      fifo_rdata = (rd_ptr < wr_ptr) ? fifo_mem[rd_ptr[7:0]] : 8'h00;
    end
  end

  // Transmit timer: BIT_CYC cycles of transmitting per byte, then byte_sent;
  // data_sent on the packet's final byte unless ds_force picks another byte.
  initial begin : timer_model
    forever begin
      @(posedge clk);
      #1;
      if (byte_sent) tm_idx++;
      byte_sent = 1'b0;
      data_sent = 1'b0;
      if (!tx_busy) tm_idx = 0;
      if (transmitting) begin
        tm_cnt++;
        if (tm_cnt == BIT_CYC) begin
          tm_cnt    = 0;
          byte_sent = 1'b1;
          if (ds_force != 0) data_sent = (tm_idx + 1 == ds_force);
          else               data_sent = (tm_idx + 1 == plen(transmit_empty));
        end
      end else begin
        tm_cnt = 0;
      end
    end
  end

  // Packet-level reference: bytes leave in FIFO order, each packet carries exactly
  // LEN bytes unless aborted/underrun, and every ending is followed by IDLE_GAP busy cycles.
  initial begin : compare
    int         tail = -1;
    logic       busy_prev = 1'b0;
    logic       cur_type = 1'b0;
    int         loads = 0;
    logic       xmit_exp = 1'b0;
    logic       exp_len_err = 1'b0;
    logic [7:0] exp_bytes [$];
    logic [7:0] head;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        busy_prev = 1'b0;
        continue;
      end
      if (tail > 0) begin
        check("gap_busy", tx_busy, 1'b1);
        tail--;
      end else if (tail == 0) begin
        check("idle_after_gap", tx_busy, 1'b0);
        tail = -1;
      end
      if (tx_busy && !busy_prev) begin
        check("start_has_request", req_rd < req_wr, 1'b1);
        if (req_rd < req_wr) begin
          cur_type = req_type[req_rd[5:0]];
          req_rd++;
        end
        loads = 0;
      end
      check("transmit_empty", transmit_empty, tx_busy ? cur_type : 1'b0);
      check("transmitting", transmitting, xmit_exp);
      check("len_err", len_err, exp_len_err);
      if (fifo_read) begin
        check("read_when_empty", fifo_empty, 1'b0);
        exp_bytes.push_back(fifo_rdata);
      end
      if (load_byte) begin
        check("load_has_data", exp_bytes.size() > 0, 1'b1);
        head = (exp_bytes.size() > 0) ? exp_bytes.pop_front() : 8'hxx;
        check("tx_byte", tx_byte, head);
        log_mem[log_n[7:0]] = tx_byte;
        log_n++;
        loads++;
        check("loads_within_len", loads <= plen(cur_type), 1'b1);
      end
      if (tx_done) begin
        check("done_len", loads, plen(cur_type));
        done_cnt++;
        tail = IDLE_GAP;
      end
      if (tx_underrun) begin
        check("underrun_short", loads < plen(cur_type), 1'b1);
        underrun_cnt++;
        tail = IDLE_GAP - 1;
      end
      if (abort && tx_busy && tail < 0) begin
        check("no_done_on_abort", tx_done, 1'b0);
        tail = IDLE_GAP;
        xmit_exp = 1'b0;
      end
      if (xmit_exp && byte_sent) begin
`ifdef TX_PKT_LEN_CHECK_EN
        if (data_sent != (loads == plen(cur_type))) exp_len_err = 1'b1;
`endif
        xmit_exp = 1'b0;
      end
      if (load_byte) xmit_exp = 1'b1;
      busy_prev = tx_busy;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_bytes(input logic [7:0] first, input int count);
    for (int i = 0; i < count; i++) begin
      fifo_mem[wr_ptr[7:0]] = first + 8'(i);
      wr_ptr++;
    end
  endtask

  task automatic start_pkt(input logic short_pkt);
    req_type[req_wr[5:0]] = short_pkt;
    req_wr++;
    tx_req   = 1'b1;
    tx_short = short_pkt;
    tick();
    tx_req   = 1'b0;
    tx_short = 1'b0;
  endtask

  task automatic wait_busy(input logic val, input int budget, input string name, output int cyc);
    cyc = 0;
    while (tx_busy !== val && cyc < budget) begin
      tick();
      cyc++;
    end
    check(name, tx_busy, val);
  endtask

  initial begin : main
    int n, cyc, b_done, b_under, b_log;
    logic exp_le;

    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs",
          {fifo_read, load_byte, tx_byte, transmitting, transmit_empty,
           tx_busy, tx_done, tx_underrun, len_err}, 16'h0000);
    n_rst = 1'b1;

    // 1: idle with data in the FIFO and no request -> nothing moves.
    push_bytes(8'h01, 5);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_quiet", {fifo_read, tx_busy, load_byte, transmitting}, 4'h0);
    end
    check("idle_tx_byte", tx_byte, 8'h00);
    $display("test 1 idle: checks=%0d", checks);

    // 2: short packet of bytes 01..05.
    b_done = done_cnt; b_under = underrun_cnt; b_log = log_n;
    start_pkt(1'b1);
    wait_busy(1'b1, 10, "t2_start", cyc);
    check("t2_type_short", transmit_empty, 1'b1);
    wait_busy(1'b0, 400, "t2_end", cyc);
    check("t2_done_once", done_cnt - b_done, 1);
    check("t2_no_underrun", underrun_cnt - b_under, 0);
    check("t2_load_count", log_n - b_log, 5);
    for (int i = 0; i < 5; i++) check("t2_byte_order", log_mem[(b_log + i) % 256], 32'(i + 1));
    $display("test 2 short packet: loads=%0d", log_n - b_log);

    // 3: long packet of 34 bytes 40..61.
    push_bytes(8'h40, 34);
    b_done = done_cnt; b_log = log_n;
    start_pkt(1'b0);
    wait_busy(1'b1, 10, "t3_start", cyc);
    check("t3_type_long", transmit_empty, 1'b0);
    wait_busy(1'b0, 1000, "t3_end", cyc);
    check("t3_done_once", done_cnt - b_done, 1);
    check("t3_load_count", log_n - b_log, 34);
    check("t3_first_byte", log_mem[b_log % 256], 8'h40);
    check("t3_last_byte", log_mem[(b_log + 33) % 256], 8'h61);
    $display("test 3 long packet: loads=%0d", log_n - b_log);

    // 4: long packet but only 10 bytes available -> underrun.
    push_bytes(8'h80, 10);
    b_done = done_cnt; b_under = underrun_cnt; b_log = log_n;
    start_pkt(1'b0);
    wait_busy(1'b1, 10, "t4_start", cyc);
    wait_busy(1'b0, 400, "t4_end", cyc);
    check("t4_underrun_once", underrun_cnt - b_under, 1);
    check("t4_no_done", done_cnt - b_done, 0);
    check("t4_load_count", log_n - b_log, 10);
    check("t4_not_transmitting", transmitting, 1'b0);
    $display("test 4 underrun: loads=%0d", log_n - b_log);

    // 5: abort coinciding with byte_sent of byte 3, new request during the gap.
    push_bytes(8'hA0, 8);
    b_done = done_cnt; b_log = log_n;
    start_pkt(1'b1);
    wait_busy(1'b1, 10, "t5_start", cyc);
    n = 0;
    while (!(byte_sent && tm_idx == 2) && n < 100) begin
      tick();
      n++;
    end
    check("t5_third_byte_seen", byte_sent && (tm_idx == 2), 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_abort_to_gap", {tx_busy, transmitting, tx_done}, 3'b100);
    start_pkt(1'b1);
    wait_busy(1'b0, 10, "t5_gap_end", cyc);
    check("t5_gap_remaining", cyc, 1);
    wait_busy(1'b1, 10, "t5_restart", cyc);
    check("t5_restart_latency", cyc, 1);
    wait_busy(1'b0, 400, "t5_end", cyc);
    check("t5_done_only_second", done_cnt - b_done, 1);
    check("t5_load_count", log_n - b_log, 8);
    check("t5_aborted_last", log_mem[(b_log + 2) % 256], 8'hA2);
    check("t5_next_first", log_mem[(b_log + 3) % 256], 8'hA3);
    $display("test 5 abort and restart: loads=%0d", log_n - b_log);

    // 6: timer reports packet end on byte 4 of a short packet.
    push_bytes(8'hC0, 5);
    b_done = done_cnt; b_log = log_n;
    ds_force = 4;
    start_pkt(1'b1);
    wait_busy(1'b1, 10, "t6_start", cyc);
    wait_busy(1'b0, 400, "t6_end", cyc);
    ds_force = 0;
`ifdef TX_PKT_LEN_CHECK_EN
    exp_le = 1'b1;
`else
    exp_le = 1'b0;
`endif
    check("t6_done_once", done_cnt - b_done, 1);
    check("t6_load_count", log_n - b_log, 5);
    check("t6_len_err", len_err, exp_le);
    repeat (5) tick();
    check("t6_len_err_sticky", len_err, exp_le);
    $display("test 6 length check: len_err=%0b", len_err);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
